sample_divider_edge: RTL and testbench

SAMPLE_DIVIDER_EDGE -- requirements
Module: sample_divider_edge

---
 rtl/sample_divider_edge_pkg.sv | 13 +
 rtl/sample_divider_count.sv | 40 ++++
 rtl/sample_divider_edge.sv | 87 ++++++++
 tb/tb_sample_divider_edge.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_divider_edge_pkg.sv
// Shared definitions for the sample divider / edge detector slice.
package sample_divider_edge_pkg;

    localparam int WIDTH_DEFAULT     = 32;
    localparam int DIV_WIDTH_DEFAULT = 24;

    // UNPRIMED: no previous kept sample to compare against.
    typedef enum logic {
        UNPRIMED = 1'b0,
        PRIMED   = 1'b1
    } edge_state_e;

endpackage

// File: rtl/sample_divider_count.sv
// Divider counter: keeps one of every (div+1) valid samples.
module sample_divider_count
    import sample_divider_edge_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 validIn,
    input  logic                 wrDivider,
    input  logic [DIV_WIDTH-1:0] config_data,
    output logic                 keep
);

    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] cnt;

    // A config write wins over a coincident sample, so that sample is never kept.
    assign keep = validIn && !wrDivider && (cnt == '0);

    // Divider register and down-counter; counter reloads from div instead of underflowing.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            div <= '0;
            cnt <= '0;
        end else if (wrDivider) begin
            div <= config_data;
            cnt <= config_data;
        end else if (validIn) begin
            if (cnt == '0) begin
                cnt <= div;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_divider_edge.sv
// Decimates a sample stream and flags per-bit edges between kept samples.
module sample_divider_edge
    import sample_divider_edge_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataIn,
    input  logic                 validIn,
    input  logic                 wrDivider,
    input  logic [DIV_WIDTH-1:0] config_data,
    output logic [WIDTH-1:0]     dataOut,
    output logic                 validOut,
    output logic [WIDTH-1:0]     risingOut,
    output logic [WIDTH-1:0]     fallingOut,
    output logic                 anyEdge
);

    logic             keep;
    edge_state_e      state;
    edge_state_e      state_next;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rising_next;
    logic [WIDTH-1:0] falling_next;

    sample_divider_count #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_count (
        .clk         (clk),
        .reset       (reset),
        .validIn     (validIn),
        .wrDivider   (wrDivider),
        .config_data (config_data),
        .keep        (keep)
    );

    // Next state and edge flags for the incoming sample.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next   = state;
        rising_next  = '0;
        falling_next = '0;
        if (state == PRIMED) begin
            rising_next  = dataIn & ~prev;
            falling_next = ~dataIn & prev;
        end
        if (wrDivider) begin
            state_next = UNPRIMED;
        end else if (keep) begin
            state_next = PRIMED;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UNPRIMED;
        end else begin
            state <= state_next;
        end
    end

    // Output registers; data and flags hold between kept samples, strobes do not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= '0;
            dataOut    <= '0;
            validOut   <= 1'b0;
            risingOut  <= '0;
            fallingOut <= '0;
            anyEdge    <= 1'b0;
        end else begin
            validOut <= keep;
            anyEdge  <= keep && (|(rising_next | falling_next));
            if (keep) begin
                prev       <= dataIn;
                dataOut    <= dataIn;
                risingOut  <= rising_next;
                fallingOut <= falling_next;
            end
        end
    end

endmodule

// File: tb/tb_sample_divider_edge.sv
// Directed bench for sample_divider_edge (WIDTH=8, DIV_WIDTH=4).
module tb_sample_divider_edge;

    localparam int WIDTH     = 8;
    localparam int DIV_WIDTH = 4;

    logic                 clk;
    logic                 reset;
    logic [WIDTH-1:0]     dataIn;
    logic                 validIn;
    logic                 wrDivider;
    logic [DIV_WIDTH-1:0] config_data;
    logic [WIDTH-1:0]     dataOut;
    logic                 validOut;
    logic [WIDTH-1:0]     risingOut;
    logic [WIDTH-1:0]     fallingOut;
    logic                 anyEdge;

    int checks = 0;
    int errors = 0;

    sample_divider_edge #(
        .WIDTH     (WIDTH),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dataIn      (dataIn),
        .validIn     (validIn),
        .wrDivider   (wrDivider),
        .config_data (config_data),
        .dataOut     (dataOut),
        .validOut    (validOut),
        .risingOut   (risingOut),
        .fallingOut  (fallingOut),
        .anyEdge     (anyEdge)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dataOut"},    32'(dataOut),    32'h0);
        check({tag, " validOut"},   32'(validOut),   32'h0);
        check({tag, " risingOut"},  32'(risingOut),  32'h0);
        check({tag, " fallingOut"}, 32'(fallingOut), 32'h0);
        check({tag, " anyEdge"},    32'(anyEdge),    32'h0);
    endtask

    task automatic check_kept(input string tag, input logic [7:0] d, input logic [7:0] r,
                              input logic [7:0] f, input logic e);
        check({tag, " validOut"},   32'(validOut),   32'h1);
        check({tag, " dataOut"},    32'(dataOut),    32'(d));
        check({tag, " risingOut"},  32'(risingOut),  32'(r));
        check({tag, " fallingOut"}, 32'(fallingOut), 32'(f));
        check({tag, " anyEdge"},    32'(anyEdge),    32'(e));
    endtask

    initial begin
        int kept_cnt;

        reset       = 1'b1;
        dataIn      = '0;
        validIn     = 1'b0;
        wrDivider   = 1'b0;
        config_data = '0;

        // Reset state, before and after clock edges.
        #1;
        check_all_zero("reset_async");
        tick();
        tick();
        check_all_zero("reset_held");
        reset = 1'b0;

        // div=0: every sample passes; first one is unprimed.
        validIn = 1'b1; dataIn = 8'h00;
        tick();
        check_kept("div0_s0", 8'h00, 8'h00, 8'h00, 1'b0);
        dataIn = 8'h01;
        tick();
        check_kept("div0_s1", 8'h01, 8'h01, 8'h00, 1'b1);
        dataIn = 8'h03;
        tick();
        check_kept("div0_s2", 8'h03, 8'h02, 8'h00, 1'b1);
        validIn = 1'b0;
        tick();
        check("idle validOut", 32'(validOut), 32'h0);
        check("idle anyEdge", 32'(anyEdge), 32'h0);
        check("idle dataOut hold", 32'(dataOut), 32'h03);
        check("idle risingOut hold", 32'(risingOut), 32'h02);

        // Falling edges with div=0.
        validIn = 1'b1; dataIn = 8'hFF;
        tick();
        check_kept("fall_s0", 8'hFF, 8'hFC, 8'h00, 1'b1);
        dataIn = 8'h0F;
        tick();
        check_kept("fall_s1", 8'h0F, 8'h00, 8'hF0, 1'b1);

        // div=3: the write reloads cnt=3, so three filler samples are dropped first,
        // then samples 0..11 yield 0,4,8.
        validIn = 1'b0; wrDivider = 1'b1; config_data = 4'd3;
        tick();
        wrDivider = 1'b0;
        check("div3 write validOut", 32'(validOut), 32'h0);
        for (int i = 0; i < 3; i++) begin
            validIn = 1'b1; dataIn = 8'hEE;
            tick();
            check("div3 filler validOut", 32'(validOut), 32'h0);
        end
        kept_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            validIn = 1'b1; dataIn = 8'(i);
            tick();
            check("div3 validOut", 32'(validOut), (i % 4 == 0) ? 32'h1 : 32'h0);
            if (validOut) begin
                kept_cnt++;
                check("div3 dataOut", 32'(dataOut), 32'(i));
            end
        end
        check("div3 kept count", 32'(kept_cnt), 32'd3);
        check("div3 last risingOut", 32'(risingOut), 32'h08);
        check("div3 last fallingOut", 32'(fallingOut), 32'h04);

        // wrDivider(1) coinciding with validIn: sample dropped, next dropped, next kept unprimed.
        validIn = 1'b1; dataIn = 8'hAA; wrDivider = 1'b1; config_data = 4'd1;
        tick();
        wrDivider = 1'b0;
        check("wrcoll validOut", 32'(validOut), 32'h0);
        check("wrcoll dataOut hold", 32'(dataOut), 32'h08);
        dataIn = 8'h11;
        tick();
        check("wrcoll drop validOut", 32'(validOut), 32'h0);
        dataIn = 8'h22;
        tick();
        check_kept("wrcoll kept", 8'h22, 8'h00, 8'h00, 1'b0);

        // Gapped input (1 of 3 cycles), div=1: cnt holds across idle cycles.
        dataIn = 8'h30;
        tick();
        check("gap drop0 validOut", 32'(validOut), 32'h0);
        validIn = 1'b0;
        tick();
        tick();
        check("gap idle0 validOut", 32'(validOut), 32'h0);
        validIn = 1'b1; dataIn = 8'h31;
        tick();
        check_kept("gap kept0", 8'h31, 8'h11, 8'h02, 1'b1);
        validIn = 1'b0;
        tick();
        check("gap idle1 anyEdge", 32'(anyEdge), 32'h0);
        tick();
        validIn = 1'b1; dataIn = 8'h32;
        tick();
        check("gap drop1 validOut", 32'(validOut), 32'h0);
        validIn = 1'b0;
        tick();
        tick();
        validIn = 1'b1; dataIn = 8'h33;
        tick();
        check_kept("gap kept1", 8'h33, 8'h02, 8'h00, 1'b1);

        // div=2, reset mid-stream between samples.
        validIn = 1'b0; wrDivider = 1'b1; config_data = 4'd2;
        tick();
        wrDivider = 1'b0;
        validIn = 1'b1; dataIn = 8'h40;
        tick();
        check("rst drop validOut", 32'(validOut), 32'h0);
        validIn = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        validIn = 1'b1; dataIn = 8'h55;
        tick();
        check_all_zero("rst_mid_clk");
        reset = 1'b0;
        dataIn = 8'h5A;
        tick();
        check_kept("rst_first", 8'h5A, 8'h00, 8'h00, 1'b0);
        dataIn = 8'h0F;
        tick();
        check_kept("rst_second", 8'h0F, 8'h05, 8'h50, 1'b1);

        // Maximum divider: keeps 1 of 16 samples.
        validIn = 1'b0; wrDivider = 1'b1; config_data = 4'hF;
        tick();
        wrDivider = 1'b0;
        kept_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            validIn = 1'b1; dataIn = 8'(i);
            tick();
            check("divmax validOut", 32'(validOut), (i % 16 == 15) ? 32'h1 : 32'h0);
            if (validOut) begin
                kept_cnt++;
                check("divmax dataOut", 32'(dataOut), 32'(i));
            end
        end
        check("divmax kept count", 32'(kept_cnt), 32'd2);
        validIn = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
